// File: rtl/multi_way_light_pkg.sv
// ============================================================================
// Module   : multi_way_light_pkg
// Purpose  : Shared state encoding, lamp codes and helpers for the
//            multi-way traffic light controller (TLC_PED_EN adds ST_WALK).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_way_light_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
`ifdef TLC_PED_EN
    ,
    ST_WALK   = 2'd3
`endif
  } tlc_state_t;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_way_light_ctrl_rr_next_way.sv
// ============================================================================
// Module   : rr_next_way
// Purpose  : Round-robin search for the next requesting way, starting just
//            after the active way; returns the active way if none requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_next_way #(
  parameter int NUM_WAY = 4
) (
  input  logic [NUM_WAY-1:0]         i_req,
  input  logic [$clog2(NUM_WAY)-1:0] i_active_way,
  output logic [$clog2(NUM_WAY)-1:0] o_next_way
);

  localparam int AW_W = $clog2(NUM_WAY);

  logic w_found;

  always_comb begin
    o_next_way = i_active_way;
    w_found    = 1'b0;
    for (int k = 1; k < NUM_WAY; k++) begin
      int idx;
      idx = int'(i_active_way) + k;
      if (idx >= NUM_WAY) idx = idx - NUM_WAY;
      if (!w_found && i_req[idx]) begin
        o_next_way = AW_W'(idx);
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_way_light_ctrl.sv
// ============================================================================
// Module   : multi_way_light_ctrl
// Purpose  : Multi-approach traffic light FSM with sticky car requests and
//            green extension. Optional pedestrian phase via macro TLC_PED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_way_light_ctrl
  import multi_way_light_pkg::*;
#(
  parameter int NUM_WAY       = 4,
  parameter int GREEN_CYC     = 35,
  parameter int MAX_GREEN_CYC = 70,
  parameter int YELLOW_CYC    = 15,
  parameter int ALLRED_CYC    = 1,
  parameter int WALK_CYC      = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WAY-1:0]         has_car,
  output logic [3*NUM_WAY-1:0]       light,
  output logic [$clog2(NUM_WAY)-1:0] active_way
`ifdef TLC_PED_EN
  ,
  input  logic                       ped_req,
  output logic                       ped_walk
`endif
);

  localparam int AW_W    = $clog2(NUM_WAY);
  localparam int MAX_CYC = max_i(max_i(max_i(GREEN_CYC, MAX_GREEN_CYC),
                                       max_i(YELLOW_CYC, ALLRED_CYC)), WALK_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] c_max_last    = CNT_W'(MAX_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_CYC - 1);
`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] c_walk_last   = CNT_W'(WALK_CYC - 1);
`endif

  tlc_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [AW_W-1:0]      r_active, w_active_nxt;
  logic [AW_W-1:0]      r_next, w_next_nxt;
  logic [AW_W-1:0]      w_rr_way;
  logic [NUM_WAY-1:0]   r_req, w_req_nxt;
  logic [NUM_WAY-1:0]   w_active_mask;
  logic [3*NUM_WAY-1:0] r_light, w_light_nxt;
  logic                 w_demand, w_extend, w_enter_green;
  logic                 w_ped_pending;
`ifdef TLC_PED_EN
  logic                 r_ped, w_ped_nxt;
  logic                 r_walk;
`endif

  function automatic logic [3*NUM_WAY-1:0] f_lights(input tlc_state_t st,
                                                    input logic [AW_W-1:0] aw);
    logic [3*NUM_WAY-1:0] v;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (aw == AW_W'(i) && st == ST_GREEN)       v[3*i +: 3] = LIGHT_GREEN;
      else if (aw == AW_W'(i) && st == ST_YELLOW) v[3*i +: 3] = LIGHT_YELLOW;
      else                                        v[3*i +: 3] = LIGHT_RED;
    end
    return v;
  endfunction

  rr_next_way #(
    .NUM_WAY      (NUM_WAY)
  ) u_rr_next_way (
    .i_req        (r_req),
    .i_active_way (r_active),
    .o_next_way   (w_rr_way)
  );

`ifdef TLC_PED_EN
  assign w_ped_pending = r_ped;
`else
  assign w_ped_pending = 1'b0;
`endif

  assign w_active_mask = NUM_WAY'(1) << r_active;
  assign w_demand      = (|(r_req & ~w_active_mask)) | w_ped_pending;
  assign w_extend      = has_car[r_active] && (r_cnt < c_max_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_next_nxt   = r_next;
    case (r_state)
      ST_GREEN: begin
        if (w_demand && (r_cnt >= c_green_last) && !w_extend) begin
          w_state_nxt = ST_YELLOW;
          w_next_nxt  = w_rr_way;
        end
      end
      ST_YELLOW: begin
        if (r_cnt >= c_yellow_last) w_state_nxt = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (r_cnt >= c_allred_last) begin
`ifdef TLC_PED_EN
          if (r_ped) begin
            w_state_nxt = ST_WALK;
          end else begin
            w_state_nxt  = ST_GREEN;
            w_active_nxt = r_next;
          end
`else
          w_state_nxt  = ST_GREEN;
          w_active_nxt = r_next;
`endif
        end
      end
`ifdef TLC_PED_EN
      ST_WALK: begin
        if (r_cnt >= c_walk_last) begin
          w_state_nxt  = ST_GREEN;
          w_active_nxt = r_next;
        end
      end
`endif
      default: w_state_nxt = ST_GREEN;
    endcase
  end

  // Counter restarts on each state entry; an idle green saturates it.
  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if (r_state == ST_GREEN && r_cnt >= c_max_last)
      w_cnt_nxt = r_cnt;
  end

  assign w_enter_green = (w_state_nxt == ST_GREEN) && (r_state != ST_GREEN);

  always_comb begin
    w_req_nxt = r_req;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (has_car[i] && !(r_state == ST_GREEN && r_active == AW_W'(i)))
        w_req_nxt[i] = 1'b1;
      if (w_enter_green && w_active_nxt == AW_W'(i))
        w_req_nxt[i] = 1'b0;
    end
  end

  assign w_light_nxt = f_lights(w_state_nxt, w_active_nxt);

`ifdef TLC_PED_EN
  assign w_ped_nxt = (r_ped | ped_req) &
                     ~((w_state_nxt == ST_WALK) && (r_state != ST_WALK));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_GREEN;
      r_cnt    <= '0;
      r_active <= '0;
      r_next   <= '0;
      r_req    <= '0;
      r_light  <= f_lights(ST_GREEN, '0);
`ifdef TLC_PED_EN
      r_ped    <= 1'b0;
      r_walk   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
      r_next   <= w_next_nxt;
      r_req    <= w_req_nxt;
      r_light  <= w_light_nxt;
`ifdef TLC_PED_EN
      r_ped    <= w_ped_nxt;
      r_walk   <= (w_state_nxt == ST_WALK);
`endif
    end
  end

  assign light      = r_light;
  assign active_way = r_active;
`ifdef TLC_PED_EN
  assign ped_walk   = r_walk;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_way_light_ctrl.sv
// ============================================================================
// Module   : tb_multi_way_light_ctrl
// Purpose  : Scoreboard bench for multi_way_light_ctrl against a phase/timer
//            reference model (pedestrian path compiled with TLC_PED_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_way_light_ctrl;

  localparam int N    = 4;
  localparam int AW_W = 2;
  localparam int G    = 35;
  localparam int MAXG = 70;
  localparam int Y    = 15;
  localparam int AR   = 1;
  localparam int W    = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   has_car = '0;
  logic [3*N-1:0] light;
  logic [AW_W-1:0] active_way;
  logic           ped_req = 1'b0;
  logic           ped_walk_s;

  multi_way_light_ctrl #(
    .NUM_WAY       (N),
    .GREEN_CYC     (G),
    .MAX_GREEN_CYC (MAXG),
    .YELLOW_CYC    (Y),
    .ALLRED_CYC    (AR),
    .WALK_CYC      (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .has_car    (has_car),
    .light      (light),
    .active_way (active_way)
`ifdef TLC_PED_EN
    ,
    .ped_req    (ped_req),
    .ped_walk   (ped_walk_s)
`endif
  );

`ifndef TLC_PED_EN
  assign ped_walk_s = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [3*N-1:0]  light;
    logic [AW_W-1:0] aw;
    logic            walk;
    logic [N-1:0]    req;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: phase 0=green 1=yellow 2=all-red 3=walk, t=cycles in phase.
  int     m_ph, m_t, m_aw, m_nw;
  bit [N-1:0] m_req;
  bit     m_ped;

  task automatic m_reset();
    m_ph = 0; m_t = 0; m_aw = 0; m_nw = 0; m_req = '0; m_ped = 0;
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (i == m_aw && m_ph == 0)      e.light[3*i +: 3] = 3'b100;
      else if (i == m_aw && m_ph == 1) e.light[3*i +: 3] = 3'b010;
      else                             e.light[3*i +: 3] = 3'b001;
    end
    e.aw   = AW_W'(m_aw);
    e.walk = (m_ph == 3);
    e.req  = m_req;
    return e;
  endfunction

  task automatic m_step(input logic [N-1:0] car, input bit r, input bit p);
    int nph, nt, naw;
    bit demand, nped;
    bit [N-1:0] nreq;
    if (r) begin
      m_reset();
      return;
    end
    nph = m_ph; naw = m_aw;
    demand = m_ped;
    for (int j = 0; j < N; j++) if (j != m_aw && m_req[j]) demand = 1;
    case (m_ph)
      0: if (demand && m_t >= G - 1 && !(car[m_aw] && m_t < MAXG - 1)) begin
           nph = 1;
           m_nw = m_aw;
           for (int k = N - 1; k >= 1; k--)
             if (m_req[(m_aw + k) % N]) m_nw = (m_aw + k) % N;
         end
      1: if (m_t == Y - 1) nph = 2;
      2: if (m_t == AR - 1) begin
           if (m_ped) nph = 3;
           else begin nph = 0; naw = m_nw; end
         end
      default: if (m_t == W - 1) begin nph = 0; naw = m_nw; end
    endcase
    if (nph != m_ph)  nt = 0;
    else if (m_ph == 0) nt = (m_t + 1 > MAXG - 1) ? MAXG - 1 : m_t + 1;
    else              nt = m_t + 1;
    for (int j = 0; j < N; j++) begin
      nreq[j] = m_req[j] | (car[j] && !(m_ph == 0 && m_aw == j));
      if (nph == 0 && m_ph != 0 && naw == j) nreq[j] = 0;
    end
    nped = m_ped | p;
    if (nph == 3 && m_ph != 3) nped = 0;
    m_ph = nph; m_t = nt; m_aw = naw; m_req = nreq; m_ped = nped;
  endtask

  task automatic do_cycle(input logic [N-1:0] car, input bit r, input bit p);
    @(negedge clk);
    exp_q.push_back(m_expect());
    rst     = r;
    has_car = car;
    ped_req = p;
    m_step(car, r, p);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin : p_monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (light !== e.light) begin
          n_err++;
          $display("FAIL light cyc=%0d got=%b exp=%b", cyc, light, e.light);
        end
        n_cmp++;
        if (active_way !== e.aw) begin
          n_err++;
          $display("FAIL active_way cyc=%0d got=%0d exp=%0d", cyc, active_way, e.aw);
        end
        n_cmp++;
        if (dut.r_req !== e.req) begin
          n_err++;
          $display("FAIL req_q cyc=%0d got=%b exp=%b", cyc, dut.r_req, e.req);
        end
        n_cmp++;
        if (ped_walk_s !== e.walk) begin
          n_err++;
          $display("FAIL ped_walk cyc=%0d got=%b exp=%b", cyc, ped_walk_s, e.walk);
        end
        cyc++;
      end
    end
  end

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  initial begin : p_stim
    logic [N-1:0] car;
    m_reset();
    repeat (2) @(posedge clk);

    // Single pulse on way 2: yellow 35..49, all-red 50, way 2 green at 51.
    do_cycle('0, 1, 0);
    for (int c = 0; c < 60; c++) do_cycle((c == 5) ? 4'b0100 : 4'b0000, 0, 0);

    // Ways 1 and 3 continuously requesting: round-robin service.
    do_cycle('0, 1, 0);
    for (int c = 0; c < 300; c++) do_cycle(4'b1010, 0, 0);

    // Way 0 holds its car: green extends to the cap.
    do_cycle('0, 1, 0);
    for (int c = 0; c < 90; c++) do_cycle(4'b0011, 0, 0);

    // No traffic: green held, never yellow.
    do_cycle('0, 1, 0);
    for (int c = 0; c < 500; c++) do_cycle(4'b0000, 0, 0);

    // Reset during yellow aborts the phase.
    do_cycle('0, 1, 0);
    for (int c = 0; c < 40; c++) do_cycle((c == 5) ? 4'b0100 : 4'b0000, 0, 0);
    do_cycle('0, 1, 0);
    for (int c = 0; c < 10; c++) do_cycle(4'b0000, 0, 0);

`ifdef TLC_PED_EN
    do_cycle('0, 1, 0);
    for (int c = 0; c < 90; c++) do_cycle('0, 0, (c == 10));
`endif

    // Random traffic with rare resets.
    do_cycle('0, 1, 0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) car[i] = ($urandom_range(0, 9) == 0);
`ifdef TLC_PED_EN
      do_cycle(car, ($urandom_range(0, 799) == 0), ($urandom_range(0, 299) == 0));
`else
      do_cycle(car, ($urandom_range(0, 799) == 0), 0);
`endif
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_way_light_ctrl.md
MULTI_WAY_LIGHT_CTRL -- requirements
Module: multi_way_light_ctrl

Interface
REQ-001 Parameter NUM_WAY, default 4: number of approaches, legal range 2..8.
REQ-002 Parameter GREEN_CYC, default 35: minimum green cycles, at least 1.
REQ-003 Parameter MAX_GREEN_CYC, default 70: green extension cap, at least GREEN_CYC.
REQ-004 Parameter YELLOW_CYC, default 15; parameter ALLRED_CYC, default 1; both at least 1.
REQ-005 Parameter WALK_CYC, default 20: pedestrian walk cycles; used only with TLC_PED_EN.
REQ-006 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port has_car, input, NUM_WAY bits: per-way car sensor, level-sensitive.
REQ-009 Port light, output, 3*NUM_WAY bits: way i occupies bits [3i+2:3i], one-hot; 100 = green, 010 = yellow, 001 = red.
REQ-010 Port active_way, output, $clog2(NUM_WAY) bits: index of the way currently holding right-of-way.
REQ-011 Port ped_req, input, 1 bit, and port ped_walk, output, 1 bit: present only with TLC_PED_EN.

Function
REQ-012 The FSM SHALL have states GREEN, YELLOW, ALLRED and, with TLC_PED_EN only, WALK; light and ped_walk SHALL be Moore outputs registered from the state.
REQ-013 A single phase counter SHALL be cleared on every state entry and incremented each cycle; its width is $clog2(max of all cycle parameters + 1).
REQ-014 Per-way sticky request register req_q: bit i is set when has_car[i]=1 and way i is not green; bit i is cleared on the cycle way i enters GREEN; when both happen in the same cycle, the clear wins.
REQ-015 Demand SHALL mean any req_q bit other than active_way is set, or, with TLC_PED_EN, ped_q is set.
REQ-016 GREEN: when counter >= GREEN_CYC-1 and demand is present, leave for YELLOW unless has_car[active_way]=1 and counter < MAX_GREEN_CYC-1, in which case hold green (extension).
REQ-017 GREEN with no demand: hold indefinitely, counter saturating at MAX_GREEN_CYC-1.
REQ-018 On GREEN->YELLOW, next_way SHALL be latched as the first set req_q bit searching round-robin from active_way+1 with wrap-around; if no such bit exists (pedestrian-only demand), next_way = active_way.
REQ-019 Requests arriving during YELLOW, ALLRED or WALK SHALL NOT change the latched next_way.
REQ-020 YELLOW SHALL last exactly YELLOW_CYC cycles, then go to ALLRED; ALLRED SHALL last exactly ALLRED_CYC cycles; all ways are red in ALLRED.
REQ-021 On ALLRED exit, go to GREEN with active_way <= next_way, except with TLC_PED_EN and ped_q=1, go to WALK.
REQ-022 During YELLOW only active_way shows 010; all other ways show 001.

Reset
REQ-023 On rst=1 at a clock edge: state=GREEN, active_way=0, next_way=0, counter=0, req_q=0, ped_q=0; light shows way 0 green and all others red; ped_walk=0.
REQ-024 Reset asserted mid-phase (including YELLOW or WALK) SHALL abort the phase immediately, with no yellow lead-out.

Configuration
REQ-025 Macro TLC_PED_EN defined: adds ped_req/ped_walk, sticky ped_q (set by ped_req, cleared on WALK entry), and state WALK (all red, ped_walk=1, WALK_CYC cycles, then GREEN of next_way).
REQ-026 Macro TLC_PED_EN undefined: no pedestrian ports, no ped_q, no WALK state; the remaining behaviour is identical.

Structure
REQ-027 Package multi_way_light_pkg SHALL hold the state enum and the light encoding constants LIGHT_GREEN, LIGHT_YELLOW and LIGHT_RED.
REQ-028 Sub-module rr_next_way (combinational round-robin search over req_q excluding active_way) SHALL implement REQ-018.

Verification
REQ-029 Defaults; reset; has_car[2] pulsed 1 cycle at cycle 5 -> way0 green cycles 0..34, yellow 35..49, all-red 50, way2 green at 51, req_q[2] cleared at 51.
REQ-030 has_car[3] and has_car[1] both high from cycle 0, way0 active -> next green way is 1, then 3 (round-robin), never 0 while has_car[0]=0.
REQ-031 has_car[0] held high and has_car[1] high from cycle 0 -> way0 green extends until cycle 69, yellow at 70.
REQ-032 No cars for 500 cycles -> way0 stays green throughout with no yellow; counter saturates.
REQ-033 rst asserted at cycle 40 (during yellow) -> next cycle way0 green, all other ways red, req_q=0.
REQ-034 TLC_PED_EN; ped_req pulsed at cycle 10 with no cars -> yellow 35..49, all-red 50, ped_walk=1 for cycles 51..70, way0 green at 71.
